// File: rtl/cbus_arbiter_pkg.sv
// CBus request/response payload types shared by the arbiter and its masters.
package cbus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SIZE_W = 3;
  localparam int unsigned LEN_W  = 8;

  typedef struct packed {
    logic              valid;
    logic              is_write;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic              ready;
    logic              last;
    logic [DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Arbitrates NUM_INPUTS CBus masters onto one CBus port; the granted request is
// held for the whole burst and responses are routed back to the granted master only.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_INPUTS  = 2,
  parameter bit          ROUND_ROBIN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t oresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  localparam int unsigned IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  cbus_req_t        saved_q, saved_d;

  logic [IDX_W-1:0] winner;
  logic             any_valid;
  int unsigned      cand;

  // Winner selection: highest index wins, or nearest requester after the last grant.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = 0;
    if (ROUND_ROBIN) begin
      // Scan farthest-to-nearest so the requester closest after ptr_q overwrites last.
      for (int unsigned k = NUM_INPUTS; k > 0; k--) begin
        cand = (32'(ptr_q) + k) % NUM_INPUTS;
        if (ireqs[cand].valid) begin
          any_valid = 1'b1;
          winner    = IDX_W'(cand);
        end
      end
    end else begin
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (ireqs[i].valid) begin
          any_valid = 1'b1;
          winner    = IDX_W'(i);
        end
      end
    end
  end

  // Next-state logic: capture the winner in IDLE, release on the last beat.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    ptr_d   = ptr_q;
    saved_d = saved_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          index_d = winner;
          saved_d = ireqs[winner];
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (oresp.ready && oresp.last) begin
          ptr_d   = index_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control fields come only from saved_q; write data/strobe track the granted master per beat.
  always_comb begin
    oreq = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      oresps[i] = '0;
    end
    if (state_q == S_BUSY) begin
      oreq        = saved_q;
      oreq.valid  = 1'b1;
      oreq.data   = ireqs[index_q].data;
      oreq.strobe = ireqs[index_q].strobe;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
        if (IDX_W'(i) == index_q) begin
          oresps[i] = oresp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      ptr_q   <= IDX_W'(NUM_INPUTS - 1);
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
      saved_q <= saved_d;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: fixed-priority and round-robin instances share stimulus.
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1000;
  localparam int NV = 18;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs [2];
  cbus_resp_t oresp;
  cbus_req_t  oreq_fp, oreq_rr;
  cbus_resp_t oresps_fp [2];
  cbus_resp_t oresps_rr [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(1'b0)) u_fp (
    .clk(clk), .reset(reset), .ireqs(ireqs), .oresps(oresps_fp), .oreq(oreq_fp), .oresp(oresp)
  );

  cbus_arbiter #(.NUM_INPUTS(2), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset(reset), .ireqs(ireqs), .oresps(oresps_rr), .oreq(oreq_rr), .oresp(oresp)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic        v1;
    logic        rdy;
    logic        last;
    logic [31:0] rdata;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic        exp_r0;
    logic        exp_r1;
    logic [31:0] exp_d0;
    logic [31:0] exp_d1;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic v1, input logic rdy,
                       input logic last, input logic [31:0] rdata);
    reset          = rst;
    ireqs[0].valid = v0;
    ireqs[1].valid = v1;
    oresp.ready    = rdy;
    oresp.last     = last;
    oresp.data     = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst v0 v1 rdy last rdata | valid addr r0 r1 d0 d1
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, DA,    1'b0, 1'b0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1, DA,    1'b0, 1'b1, 32'h0, 32'h5555_AAAA};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7777_0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, IA,    1'b0, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3C08_BFAF, 1'b1, IA,    1'b1, 1'b0, 32'h3C08_BFAF, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, DA,    1'b0, 1'b0, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, DA,    1'b0, 1'b1, 32'h0, 32'h1234_5678};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 1'b1, IA,    1'b1, 1'b0, 32'hCAFE_0001, 32'h0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hCAFE_0002, 1'b1, IA,    1'b1, 1'b0, 32'hCAFE_0002, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};

    ireqs[0] = '{valid: 1'b0, is_write: 1'b0, size: 3'd2, addr: IA, strobe: 4'h0, data: 32'h0, len: 8'd0};
    ireqs[1] = '{valid: 1'b0, is_write: 1'b1, size: 3'd2, addr: DA, strobe: 4'hF, data: 32'h0, len: 8'd3};
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    next_cycle();

    // Reset, single read, fixed-priority contention
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].v1, vecs[i].rdy, vecs[i].last, vecs[i].rdata);
      #2;
      chk($sformatf("vec%0d_valid", i), 32'(oreq_fp.valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_addr", i), oreq_fp.addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_r0", i), 32'(oresps_fp[0].ready), 32'(vecs[i].exp_r0));
      chk($sformatf("vec%0d_r1", i), 32'(oresps_fp[1].ready), 32'(vecs[i].exp_r1));
      chk($sformatf("vec%0d_d0", i), oresps_fp[0].data, vecs[i].exp_d0);
      chk($sformatf("vec%0d_d1", i), oresps_fp[1].data, vecs[i].exp_d1);
      next_cycle();
    end

    // Round-robin: both request continuously, every BUSY cycle completes a 1-beat burst
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0000);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) next_cycle();
      #2;
      chk($sformatf("rr%0d_valid", c), 32'(oreq_rr.valid), 32'(c % 2));
      if (c % 2 == 1) begin
        chk($sformatf("rr%0d_addr", c), oreq_rr.addr, ((c / 2) % 2 == 1) ? DA : IA);
        chk($sformatf("rr%0d_r0", c), 32'(oresps_rr[0].ready), 32'((c / 2) % 2 == 0));
        chk($sformatf("rr%0d_r1", c), 32'(oresps_rr[1].ready), 32'((c / 2) % 2 == 1));
      end
    end

    // Burst write on dbus, len=3, one wait state, valid drop at beat 2 ignored
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    ireqs[1].data = 32'hA000_0000;
    #2;
    chk("wr_idle_valid", 32'(oreq_fp.valid), 32'd0);
    next_cycle();
    #2;
    chk("wr_wait_valid", 32'(oreq_fp.valid), 32'd1);
    chk("wr_wait_len", 32'(oreq_fp.len), 32'd3);
    chk("wr_wait_is_write", 32'(oreq_fp.is_write), 32'd1);
    chk("wr_wait_r1", 32'(oresps_fp[1].ready), 32'd0);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      drive(1'b0, 1'b0, (b != 2), 1'b1, (b == 3), 32'h0);
      ireqs[1].data = 32'hA000_0000 + 32'(b);
      #2;
      chk($sformatf("wr_b%0d_valid", b), 32'(oreq_fp.valid), 32'd1);
      chk($sformatf("wr_b%0d_addr", b), oreq_fp.addr, DA);
      chk($sformatf("wr_b%0d_len", b), 32'(oreq_fp.len), 32'd3);
      chk($sformatf("wr_b%0d_data", b), oreq_fp.data, 32'hA000_0000 + 32'(b));
      chk($sformatf("wr_b%0d_strobe", b), 32'(oreq_fp.strobe), 32'hF);
      chk($sformatf("wr_b%0d_r1", b), 32'(oresps_fp[1].ready), 32'd1);
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("wr_done_valid", 32'(oreq_fp.valid), 32'd0);

    // Mid-burst reset at beat 2, then a clean ibus grant
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    chk("mr_idle_valid", 32'(oreq_fp.valid), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("mr_b1_valid", 32'(oreq_fp.valid), 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("mr_b2_valid", 32'(oreq_fp.valid), 32'd1);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    chk("mr_after_valid", 32'(oreq_fp.valid), 32'd0);
    chk("mr_after_r1", 32'(oresps_fp[1].ready), 32'd0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("mr_new_valid", 32'(oreq_fp.valid), 32'd1);
    chk("mr_new_addr", oreq_fp.addr, IA);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0BAD_F00D);
    #2;
    chk("mr_new_d0", oresps_fp[0].data, 32'h0BAD_F00D);
    chk("mr_new_r1", 32'(oresps_fp[1].ready), 32'd0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("mr_end_valid", 32'(oreq_fp.valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
